// File: rtl/ivector_rr_sched.sv
// ivector_rr_sched: fair round-robin drain of NUM lane FIFOs into one registered heard output stage,
// with optional per-lane burst holding and a runtime lane-enable mask.
module ivector_rr_sched #(
    parameter int NUM   = 10,
    parameter int WIDTH = 32,
    parameter int IDXW  = 4,
    parameter int BURST = 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NUM-1:0]       lane_rdy,
    input  logic [NUM*WIDTH-1:0] lane_data,
    input  logic [NUM-1:0]       lane_en,
    output logic [NUM-1:0]       lane_deq__ENA,
    output logic                 heard__ENA,
    input  logic                 heard__RDY,
    output logic [IDXW-1:0]      heard_meth,
    output logic [WIDTH-1:0]     heard_v
);
    localparam int CW = $clog2(BURST + 1);
    logic [NUM-1:0]   w_elig;
    logic [IDXW-1:0]  w_rot, w_j, w_g, r_ptr, r_meth;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_v;
    logic             r_prev, r_ena, w_more, w_hold, w_grant;

    assign w_elig  = lane_rdy & lane_en;
    assign w_more  = ({1'b0, r_cnt} + (CW + 1)'(1)) < (CW + 1)'(BURST);
    // r_ptr always names the previous grantee, so burst hold just re-grants it
    assign w_hold  = r_prev && w_elig[r_ptr] && w_more;
    assign w_grant = !RST && (!r_ena || heard__RDY) && (|w_elig);
    assign w_g     = w_hold ? r_ptr : w_rot;
    assign lane_deq__ENA = w_grant ? {{(NUM-1){1'b0}}, 1'b1} << w_g : '0;
    assign heard__ENA = r_ena;
    assign heard_meth = r_meth;
    assign heard_v    = r_v;

    // Descending scan so the nearest lane after r_ptr wins; r_ptr itself is checked last
    always_comb begin
        w_rot = r_ptr;
        w_j   = '0;
        for (int k = NUM; k >= 1; k--) begin
            w_j = IDXW'((int'(r_ptr) + k) % NUM);
            if (w_elig[w_j]) w_rot = w_j;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ena  <= 1'b0;
            r_meth <= '0;
            r_v    <= '0;
            r_ptr  <= IDXW'(NUM - 1);
            r_cnt  <= '0;
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_grant;
            if (w_grant) begin
                r_ena  <= 1'b1;
                r_meth <= w_g;
                r_v    <= lane_data[w_g*WIDTH +: WIDTH];
                r_ptr  <= w_g;
                r_cnt  <= (r_prev && w_g == r_ptr) ? r_cnt + CW'(w_more) : '0;
            end else begin
                r_cnt <= '0;
                if (heard__RDY) r_ena <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ivector_rr_sched.sv
// tb_ivector_rr_sched: directed checks of round-robin order, burst hold, backpressure,
// lane masking and reset, on a BURST=1 and a BURST=3 instance sharing the same inputs.
module tb_ivector_rr_sched;
    logic         CLK = 1'b0, RST = 1'b1, hrdy = 1'b1;
    logic [9:0]   rdy = '0, en = '1;
    logic [319:0] data;
    logic [9:0]   deq1, deq3;
    logic         ena1, ena3;
    logic [3:0]   meth1, meth3;
    logic [31:0]  v1, v3;
    int checks = 0, errors = 0;
    int s1[9] = '{2, 2, 2, 5, 5, 5, 2, 2, 2};
    int s2[5] = '{2, 2, 5, 5, 5};

    ivector_rr_sched #(.NUM(10), .WIDTH(32), .IDXW(4), .BURST(1)) u1 (
        .CLK(CLK), .RST(RST), .lane_rdy(rdy), .lane_data(data), .lane_en(en),
        .lane_deq__ENA(deq1), .heard__ENA(ena1), .heard__RDY(hrdy),
        .heard_meth(meth1), .heard_v(v1));

    ivector_rr_sched #(.NUM(10), .WIDTH(32), .IDXW(4), .BURST(3)) u3 (
        .CLK(CLK), .RST(RST), .lane_rdy(rdy), .lane_data(data), .lane_en(en),
        .lane_deq__ENA(deq3), .heard__ENA(ena3), .heard__RDY(hrdy),
        .heard_meth(meth3), .heard_v(v3));

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset;
        RST = 1'b1;
        tick();
        RST = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 10; i++) data[i*32 +: 32] = 32'h1000 + 32'(i);
        do_reset();
        chk("rst_ena1", 32'(ena1), 0);
        chk("rst_meth1", 32'(meth1), 0);
        chk("rst_v1", v1, 0);
        chk("rst_ena3", 32'(ena3), 0);

        rdy = '1; en = '1; hrdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            chk("rr_deq", 32'(deq1), 32'(10'd1 << (c % 10)));
            chk("rr_onehot", 32'($countones(deq1)), 1);
            if (c == 0) chk("rr_first_ena", 32'(ena1), 0);
            tick();
            chk("rr_meth", 32'(meth1), 32'(c % 10));
            chk("rr_v", v1, 32'h1000 + 32'(c % 10));
            chk("rr_ena", 32'(ena1), 1);
        end

        do_reset();
        rdy = 10'h080;
        #1;
        chk("pair_seed_deq", 32'(deq1), 32'h80);
        tick();
        chk("pair_seed_meth", 32'(meth1), 7);
        rdy = 10'h088;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("pair_deq", 32'(deq1), 32'(10'd1 << ((k % 2 == 1) ? 7 : 3)));
            tick();
            chk("pair_meth", 32'(meth1), (k % 2 == 1) ? 7 : 3);
        end

        do_reset();
        rdy = 10'h024;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("burst_deq", 32'(deq3), 32'(10'd1 << s1[k]));
            tick();
            chk("burst_meth", 32'(meth3), 32'(s1[k]));
        end
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rdy = (k < 2) ? 10'h024 : 10'h020;
            #1;
            chk("burst_drop_deq", 32'(deq3), 32'(10'd1 << s2[k]));
            tick();
            chk("burst_drop_meth", 32'(meth3), 32'(s2[k]));
        end

        do_reset();
        data[4*32 +: 32] = 32'hDEADBEEF;
        rdy = 10'h010; hrdy = 1'b1;
        #1;
        chk("bp_first_deq", 32'(deq1), 32'h10);
        tick();
        chk("bp_first_v", v1, 32'hDEADBEEF);
        data[4*32 +: 32] = 32'hCAFEF00D;
        hrdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("bp_hold_deq", 32'(deq1), 0);
            tick();
            chk("bp_hold_ena", 32'(ena1), 1);
            chk("bp_hold_meth", 32'(meth1), 4);
            chk("bp_hold_v", v1, 32'hDEADBEEF);
        end
        hrdy = 1'b1;
        #1;
        chk("bp_release_deq", 32'(deq1), 32'h10);
        tick();
        chk("bp_release_v", v1, 32'hCAFEF00D);
        chk("bp_release_ena", 32'(ena1), 1);

        rdy = 10'h002; en = 10'h3FD;
        #1;
        chk("mask_deq0", 32'(deq1), 0);
        tick();
        chk("mask_ena0", 32'(ena1), 0);
        #1;
        chk("mask_deq1", 32'(deq1), 0);
        tick();
        chk("mask_ena1", 32'(ena1), 0);
        en = '1;
        #1;
        chk("unmask_deq", 32'(deq1), 32'h2);
        tick();
        chk("unmask_ena", 32'(ena1), 1);
        chk("unmask_meth", 32'(meth1), 1);

        rdy = '1; RST = 1'b1;
        #1;
        chk("midrst_deq1", 32'(deq1), 0);
        chk("midrst_deq3", 32'(deq3), 0);
        tick();
        RST = 1'b0;
        chk("midrst_ena", 32'(ena1), 0);
        chk("midrst_meth", 32'(meth1), 0);
        chk("midrst_v", v1, 0);
        rdy = 10'h120;
        #1;
        chk("postrst_deq", 32'(deq1), 32'h20);
        tick();
        chk("postrst_meth", 32'(meth1), 5);
        chk("postrst_v", v1, 32'h1005);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ivector_rr_sched.md
# ivector_rr_sched

Round-robin drain scheduler for a bank of NUM per-lane FIFOs feeding one shared `heard` indication port. It replaces fixed lowest-index-wins selection with fair arbitration, optional per-lane burst holding and a runtime lane-enable mask. The winning entry is registered into a single output stage. It sits between the FIFO bank's dequeue side and the downstream indication client.

## Interface
Parameters:
- NUM, 10: number of lanes/FIFOs.
- WIDTH, 32: payload width per lane.
- IDXW, 4: lane index width, at least clog2(NUM).
- BURST, 1: maximum consecutive grants to one lane before the grant must rotate. Must be at least 1.

Ports:
- CLK  in  1  clock; all logic is on its rising edge.
- RST  in  1  reset, synchronous, active-high.
- lane_rdy  in  NUM  bit i = FIFO i first__RDY && deq__RDY.
- lane_data  in  NUM*WIDTH  FIFO i first payload, in bits [i*WIDTH +: WIDTH].
- lane_en  in  NUM  lane enable mask; a 0 bit excludes that lane from arbitration.
- lane_deq__ENA  out  NUM  one-hot or zero; dequeue strobe to FIFO i.
- heard__ENA  out  1  output stage holds a valid entry.
- heard__RDY  in  1  downstream accepts the entry this cycle.
- heard$meth  out  IDXW  lane index of the held entry.
- heard$v  out  WIDTH  payload of the held entry.

## Operation
- Eligible lanes: elig = lane_rdy & lane_en.
- The output slot is free when !heard__ENA || heard__RDY, i.e. empty or being consumed this cycle.
- Grant is evaluated only when the slot is free and elig != 0.
- Burst hold: the previous grantee g keeps the grant if all of the following hold:
  - elig[g] is set;
  - burst_cnt < BURST-1;
  - the last grant occurred in the immediately preceding cycle.
- Otherwise the scheduler rotates: it picks the first eligible lane scanning ptr+1, ptr+2, … modulo NUM, with wrap from NUM-1 to 0.
- On grant to lane g (all combinational in the same cycle):
  - lane_deq__ENA[g]=1;
  - the output register loads heard$meth=g and heard$v=lane_data[g];
  - heard__ENA=1 on the next edge;
  - ptr<=g.
- burst_cnt update: if g equals the previous grantee and the grant is back-to-back, burst_cnt<=burst_cnt+1; otherwise burst_cnt<=0.
- With BURST=1 the scheduler is pure round-robin.
- No grant this cycle:
  - burst_cnt<=0;
  - if heard__RDY && heard__ENA, then heard__ENA<=0;
  - otherwise the output stage holds its values.
- heard$meth and heard$v stay stable while heard__ENA && !heard__RDY.
- At most one lane_deq__ENA bit is high per cycle.
- lane_deq__ENA[i] is never high unless lane_rdy[i] && lane_en[i] in that same cycle.
- Clearing lane_en[g] mid-burst ends the burst immediately; an already captured entry is still delivered.
- Reset values, with RST high at an edge:
  - heard__ENA=0, heard$meth=0, heard$v=0;
  - ptr=NUM-1, so lane 0 has first priority;
  - burst_cnt=0.
- lane_deq__ENA is forced to 0 in every cycle where RST is high. An entry held at reset is discarded.

## Timing
- Latency: 1 cycle from the lane_rdy/grant cycle to heard__ENA.
- Throughput: 1 entry/cycle while heard__RDY stays high and elig != 0. The same-cycle consume-and-refill path has no bubble.
- Backpressure: if heard__ENA && !heard__RDY, there is no grant and no lane_deq__ENA. Arbitration state (ptr, burst_cnt) is frozen except that burst_cnt resets because the back-to-back condition is broken.
- lane_deq__ENA is combinational from lane_rdy, lane_en, heard__RDY and registered state. It has no path from lane_data.
- The RST assertion takes effect at the next CLK edge. Outputs are at reset values in the cycle after that edge.

## Test plan
- Reset, then lane_rdy=all ones, lane_en=all ones, BURST=1, heard__RDY=1 held:
  - heard$meth sequence is 0,1,…,9,0,1 on consecutive cycles;
  - first heard__ENA appears 1 cycle after the first grant;
  - exactly one lane_deq__ENA bit is high per cycle.
- Only lanes 3 and 7 ready, ptr=7, BURST=1:
  - grants alternate 3,7,3,7, including wrap-around through index 9→0;
  - lanes 3 and 7 are never starved.
- BURST=3, lanes 2 and 5 continuously ready:
  - heard$meth reads 2,2,2,5,5,5,2,2,2;
  - dropping lane_rdy[2] after its 2nd beat yields 2,2,5,5,5.
- Backpressure: hold heard__RDY=0 for 4 cycles with lane 4 holding payload 0xDEADBEEF:
  - heard$v=0xDEADBEEF and heard$meth=4 stay stable for those 4 cycles;
  - lane_deq__ENA=0 throughout;
  - on release, the next grant occurs in the same cycle as the consume.
- Clear lane_en[1] while lane 1 is ready and all other lanes are idle: no grant and heard__ENA deasserts after the held entry is consumed. Re-enabling lane 1 produces a grant in the following cycle.
- Assert RST for 1 cycle mid-stream with heard__ENA=1: heard__ENA=0 after the edge and lane_deq__ENA=0 during the reset cycle. The first post-reset grant goes to the lowest eligible index.
